ram_arbiter: RTL

Sequential arbiter and SRAM cycle sequencer that shares the single off-chip RAM between instruction fetch (IF) and the data-memory stage (MEM). It sits between the pipeline's fetch unit / MEM stage and the SRAM pins. It grants one request at a time, with MEM having priority over IF, and generates the CE/OE/WE strobe sequence. It also raises `stall` so the pipeline freezes while an access is pending.

---
 rtl/ram_arbiter_pkg.sv | 29 ++
 rtl/ram_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the SRAM arbiter: bus widths, op codes, FSM states
// and grant identifiers.
package ram_arbiter_pkg;

  localparam int CPU_ADDR_W    = 16;
  localparam int SRAM_ADDR_BUS = 18;
  localparam int SRAM_DATA_BUS = 16;

  // Memory operation code carried by the MEM stage.
  localparam logic RAM_OP_RD = 1'b0;
  localparam logic RAM_OP_WR = 1'b1;

  // Write-pulse down-counter width; covers WR_CYCLES up to 7.
  localparam int WR_CNT_W = 3;

  typedef enum logic [2:0] {
    ARB_ST_IDLE     = 3'd0,
    ARB_ST_RD       = 3'd1,
    ARB_ST_WR_SETUP = 3'd2,
    ARB_ST_WR_PULSE = 3'd3,
    ARB_ST_WR_HOLD  = 3'd4
  } arb_state_e;

  typedef enum logic {
    ARB_GNT_IF  = 1'b0,
    ARB_GNT_MEM = 1'b1
  } arb_gnt_e;

endpackage

// File: rtl/ram_arbiter.sv
// Shares one asynchronous SRAM between instruction fetch and the MEM stage.
// MEM wins over IF; one access at a time; every pin-facing output, ack and
// data register is registered. Handshake: a port holds req (and its
// address/data) high until it sees a one-cycle ack; while ack is high the
// port is not eligible for a new grant, so a held req is served once.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = SRAM_ADDR_BUS,
  parameter int DATA_W    = SRAM_DATA_BUS,
  parameter int WR_CYCLES = 2
) (
  input  logic                  clk_50MHz,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [CPU_ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0]     if_data,
  output logic                  if_ack,
  input  logic                  mem_req,
  input  logic                  mem_op,
  input  logic [CPU_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_ack,
  output logic                  stall,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_dq_o,
  output logic                  sram_dq_oe,
  input  logic [DATA_W-1:0]     sram_dq_i,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output arb_state_e            dbg_state
);

  // Value loaded into the pulse counter on entering WR_PULSE; the pulse
  // ends on the cycle the counter reads zero, giving WR_CYCLES cycles.
  localparam logic [WR_CNT_W-1:0] PULSE_LAST = WR_CNT_W'(WR_CYCLES - 1);

  arb_state_e            state_q, state_d;
  arb_gnt_e              gnt_q, gnt_d;
  logic [WR_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     dq_o_q, dq_o_d;
  logic                  dq_oe_q, dq_oe_d;
  logic                  ce_n_q, ce_n_d;
  logic                  oe_n_q, oe_n_d;
  logic                  we_n_q, we_n_d;
  logic                  if_ack_q, if_ack_d;
  logic                  mem_ack_q, mem_ack_d;
  logic [DATA_W-1:0]     if_data_q, if_data_d;
  logic [DATA_W-1:0]     mem_rdata_q, mem_rdata_d;

  // Arbitration, strobe sequencing and data capture (next-state logic).
  // The operation is not stored separately: it is implied by which branch
  // (RD or WR_*) the FSM took at grant time.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    dq_o_d      = dq_o_q;
    dq_oe_d     = dq_oe_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      ARB_ST_IDLE: begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        if (mem_req && !mem_ack_q) begin
          gnt_d  = ARB_GNT_MEM;
          addr_d = ADDR_W'(mem_addr);
          ce_n_d = 1'b0;
          if (mem_op == RAM_OP_WR) begin
            dq_o_d  = mem_wdata;
            dq_oe_d = 1'b1;
            state_d = ARB_ST_WR_SETUP;
          end else begin
            oe_n_d  = 1'b0;
            state_d = ARB_ST_RD;
          end
        end else if (if_req && !if_ack_q) begin
          gnt_d   = ARB_GNT_IF;
          addr_d  = ADDR_W'(if_addr);
          ce_n_d  = 1'b0;
          oe_n_d  = 1'b0;
          state_d = ARB_ST_RD;
        end
      end

      ARB_ST_RD: begin
        if (gnt_q == ARB_GNT_IF) begin
          if_data_d = sram_dq_i;
          if_ack_d  = 1'b1;
        end else begin
          mem_rdata_d = sram_dq_i;
          mem_ack_d   = 1'b1;
        end
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        state_d = ARB_ST_IDLE;
      end

      ARB_ST_WR_SETUP: begin
        we_n_d  = 1'b0;
        cnt_d   = PULSE_LAST;
        state_d = ARB_ST_WR_PULSE;
      end

      ARB_ST_WR_PULSE: begin
        if (cnt_q == '0) begin
          we_n_d  = 1'b1;
          state_d = ARB_ST_WR_HOLD;
        end else begin
          cnt_d = cnt_q - WR_CNT_W'(1);
        end
      end

      ARB_ST_WR_HOLD: begin
        ce_n_d    = 1'b1;
        dq_oe_d   = 1'b0;
        mem_ack_d = 1'b1;
        state_d   = ARB_ST_IDLE;
      end

      default: begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        state_d = ARB_ST_IDLE;
      end
    endcase
  end

  // State and output registers; async reset parks the pins inactive at once.
  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_ST_IDLE;
      gnt_q       <= ARB_GNT_IF;
      cnt_q       <= '0;
      addr_q      <= '0;
      dq_o_q      <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      dq_o_q      <= dq_o_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign stall      = (if_req & ~if_ack_q) | (mem_req & ~mem_ack_q);
  assign if_data    = if_data_q;
  assign if_ack     = if_ack_q;
  assign mem_rdata  = mem_rdata_q;
  assign mem_ack    = mem_ack_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign dbg_state  = state_q;

endmodule
